tx_iq_axis_buffer: RTL and testbench

//  - Output stage directly downstream of TX_phy: captures the I/Q sample stream
//    (db_sub_i/db_sub_q plus a sample strobe) into a shared FIFO.
//  - Presents the samples as two lock-stepped AXI-Stream channels (tx_i_axis_*,
//    tx_q_axis_*) with real backpressure, replacing the constant-valid hookup.
//  - Prefills before starting, zero-fills on underrun, and counts overflows
//    and underruns.

---
 rtl/tx_iq_axis_buffer_if.sv | 30 +++
 rtl/tx_iq_axis_buffer.sv | 128 ++++++++++++
 tb/tb_tx_iq_axis_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_iq_axis_buffer_if.sv
// Lock-stepped I/Q AXI-Stream pair leaving the TX output buffer.
// The master drives data/valid; the slave drives both readys.
interface tx_iq_axis_buffer_if #(
  parameter int pDAT_W = 16
);
  logic [pDAT_W-1:0] tx_i_axis_tdata;
  logic              tx_i_axis_tvalid;
  logic              tx_i_axis_tready;
  logic [pDAT_W-1:0] tx_q_axis_tdata;
  logic              tx_q_axis_tvalid;
  logic              tx_q_axis_tready;

  modport master (
    output tx_i_axis_tdata,
    output tx_i_axis_tvalid,
    input  tx_i_axis_tready,
    output tx_q_axis_tdata,
    output tx_q_axis_tvalid,
    input  tx_q_axis_tready
  );

  modport slave (
    input  tx_i_axis_tdata,
    input  tx_i_axis_tvalid,
    output tx_i_axis_tready,
    input  tx_q_axis_tdata,
    input  tx_q_axis_tvalid,
    output tx_q_axis_tready
  );
endinterface

// File: rtl/tx_iq_axis_buffer.sv
// TX_phy I/Q sample FIFO feeding two lock-stepped AXIS channels,
// with prefill, optional zero-fill on underrun and drop counters.
module tx_iq_axis_buffer #(
  parameter int pDAT_W     = 16,
  parameter int pADDR_W    = 5,
  parameter int pSTART_LVL = 16,
  parameter int pZERO_FILL = 1
) (
  input  logic                clk_h,
  input  logic                rst,
  input  logic                flush,
  input  logic [pDAT_W-1:0]   isample_i,
  input  logic [pDAT_W-1:0]   isample_q,
  input  logic                isample_val,
  tx_iq_axis_buffer_if.master tx,
  output logic [pADDR_W:0]    olevel,
  output logic                orun,
  output logic [15:0]         oovf_cnt,
  output logic [15:0]         oudf_cnt
);

  localparam int D = 2**pADDR_W;
  localparam logic [pADDR_W:0] LVL_FULL  = (pADDR_W+1)'(D);
  localparam logic [pADDR_W:0] LVL_START = (pADDR_W+1)'(pSTART_LVL);
  localparam logic [pADDR_W:0] ONE = (pADDR_W+1)'(1);

  typedef enum logic {
    PREFILL,
    RUN
  } state_t;

  state_t state, state_nxt;

  logic [2*pDAT_W-1:0] mem [D];
  logic [pADDR_W-1:0]  wr_ptr, rd_ptr;
  logic [pADDR_W:0]    level, level_nxt;
  logic                zp, zp_nxt;
  logic                empty, full;
  logic                zero_beat, data_beat, tvalid;
  logic                pop, data_pop, zero_pop, wr;
  logic [15:0]         ovf_cnt, udf_cnt;
  logic [2*pDAT_W-1:0] head;

  // zp latches a presented zero beat so a late sample cannot replace it
  always_comb begin
    empty     = (level == '0);
    full      = (level == LVL_FULL);
    zero_beat = (state == RUN) &
                (zp | (empty & (pZERO_FILL != 0)));
    data_beat = (state == RUN) & ~zero_beat & ~empty;
    tvalid    = zero_beat | data_beat;
    pop       = tvalid & tx.tx_i_axis_tready
                       & tx.tx_q_axis_tready;
    data_pop  = pop & data_beat;
    zero_pop  = pop & zero_beat;
    wr        = isample_val & (~full | data_pop);
    level_nxt = level;
    if (wr & ~data_pop)
      level_nxt = level + ONE;
    else if (data_pop & ~wr)
      level_nxt = level - ONE;
    zp_nxt    = zero_beat & ~pop;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PREFILL:
        if (level_nxt >= LVL_START)
          state_nxt = RUN;
      RUN:
        if (empty && pZERO_FILL == 0)
          state_nxt = PREFILL;
      default:
        state_nxt = PREFILL;
    endcase
  end

  always_ff @(posedge clk_h or posedge rst) begin
    if (rst) begin
      state   <= PREFILL;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      zp      <= 1'b0;
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else if (flush) begin
      state   <= PREFILL;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      zp      <= 1'b0;
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      zp    <= zp_nxt;
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (data_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (isample_val & ~wr & (ovf_cnt != 16'hFFFF))
        ovf_cnt <= ovf_cnt + 16'd1;
      if (zero_pop & (udf_cnt != 16'hFFFF))
        udf_cnt <= udf_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_h) begin
    if (wr & ~flush)
      mem[wr_ptr] <= {isample_i, isample_q};
  end

  assign head = data_beat ? mem[rd_ptr] : '0;

  assign tx.tx_i_axis_tdata  = head[2*pDAT_W-1:pDAT_W];
  assign tx.tx_q_axis_tdata  = head[pDAT_W-1:0];
  assign tx.tx_i_axis_tvalid = tvalid;
  assign tx.tx_q_axis_tvalid = tvalid;

  assign olevel   = level;
  assign orun     = (state == RUN);
  assign oovf_cnt = ovf_cnt;
  assign oudf_cnt = udf_cnt;

endmodule

// File: tb/tb_tx_iq_axis_buffer.sv
// Bench: dut 0 zero-fills, dut 1 re-prefills; both share stimulus
// and are compared every cycle against a queue-based model.
module tb_tx_iq_axis_buffer;
  localparam int W  = 16;
  localparam int AW = 5;
  localparam int D  = 32;
  localparam int SL = 16;

  logic clk_h = 1'b0;
  logic rst, flush, val, ri, rq;
  logic [W-1:0] si, sq;

  always #5 clk_h = ~clk_h;

  tx_iq_axis_buffer_if #(.pDAT_W(W)) ax0 ();
  tx_iq_axis_buffer_if #(.pDAT_W(W)) ax1 ();

  assign ax0.tx_i_axis_tready = ri;
  assign ax0.tx_q_axis_tready = rq;
  assign ax1.tx_i_axis_tready = ri;
  assign ax1.tx_q_axis_tready = rq;

  logic [AW:0]  o_lvl [2];
  logic         o_run [2];
  logic [15:0]  o_ovf [2];
  logic [15:0]  o_udf [2];
  logic         o_vi  [2];
  logic         o_vq  [2];
  logic [W-1:0] o_di  [2];
  logic [W-1:0] o_dq  [2];

  tx_iq_axis_buffer #(
    .pDAT_W(W), .pADDR_W(AW),
    .pSTART_LVL(SL), .pZERO_FILL(1)
  ) u_zf (
    .clk_h(clk_h), .rst(rst), .flush(flush),
    .isample_i(si), .isample_q(sq),
    .isample_val(val), .tx(ax0),
    .olevel(o_lvl[0]), .orun(o_run[0]),
    .oovf_cnt(o_ovf[0]), .oudf_cnt(o_udf[0])
  );

  tx_iq_axis_buffer #(
    .pDAT_W(W), .pADDR_W(AW),
    .pSTART_LVL(SL), .pZERO_FILL(0)
  ) u_nz (
    .clk_h(clk_h), .rst(rst), .flush(flush),
    .isample_i(si), .isample_q(sq),
    .isample_val(val), .tx(ax1),
    .olevel(o_lvl[1]), .orun(o_run[1]),
    .oovf_cnt(o_ovf[1]), .oudf_cnt(o_udf[1])
  );

  assign o_vi[0] = ax0.tx_i_axis_tvalid;
  assign o_vq[0] = ax0.tx_q_axis_tvalid;
  assign o_di[0] = ax0.tx_i_axis_tdata;
  assign o_dq[0] = ax0.tx_q_axis_tdata;
  assign o_vi[1] = ax1.tx_i_axis_tvalid;
  assign o_vq[1] = ax1.tx_q_axis_tvalid;
  assign o_di[1] = ax1.tx_i_axis_tdata;
  assign o_dq[1] = ax1.tx_q_axis_tdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, int z,
                     logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h want %0h",
               nm, z, act, exp);
    end
  endtask

  logic [31:0] mq [2][$];
  bit          m_run [2];
  bit          m_zp  [2];
  int          m_ovf [2];
  int          m_udf [2];

  function automatic bit m_zero(int z);
    return m_run[z] &&
           (m_zp[z] || (mq[z].size() == 0 && z == 0));
  endfunction

  function automatic bit m_valid(int z);
    return m_zero(z) || (m_run[z] && mq[z].size() > 0);
  endfunction

  function automatic logic [31:0] m_data(int z);
    if (m_valid(z) && !m_zero(z))
      return mq[z][0];
    return 32'h0;
  endfunction

  task automatic m_clear();
    for (int z = 0; z < 2; z++) begin
      mq[z].delete();
      m_run[z] = 1'b0;
      m_zp[z]  = 1'b0;
      m_ovf[z] = 0;
      m_udf[z] = 0;
    end
  endtask

  task automatic m_edge();
    for (int z = 0; z < 2; z++) begin
      bit zb, vb, pop, dpop;
      int sz;
      if (flush) begin
        mq[z].delete();
        m_run[z] = 1'b0;
        m_zp[z]  = 1'b0;
        m_ovf[z] = 0;
        m_udf[z] = 0;
        continue;
      end
      zb   = m_zero(z);
      vb   = m_valid(z);
      sz   = mq[z].size();
      pop  = vb && ri && rq;
      dpop = pop && !zb;
      if (dpop)
        void'(mq[z].pop_front());
      if (pop && zb && m_udf[z] < 65535)
        m_udf[z]++;
      if (val) begin
        if (sz < D || dpop)
          mq[z].push_back({si, sq});
        else if (m_ovf[z] < 65535)
          m_ovf[z]++;
      end
      m_zp[z] = zb && !pop;
      if (!m_run[z])
        m_run[z] = (mq[z].size() >= SL);
      else if (sz == 0 && z == 1)
        m_run[z] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int z = 0; z < 2; z++) begin
      logic [31:0] d;
      d = m_data(z);
      chk("tvalid_i", z, 32'(o_vi[z]), 32'(m_valid(z)));
      chk("tvalid_q", z, 32'(o_vq[z]), 32'(m_valid(z)));
      chk("tdata_i", z, 32'(o_di[z]), 32'(d[31:16]));
      chk("tdata_q", z, 32'(o_dq[z]), 32'(d[15:0]));
      chk("olevel", z, 32'(o_lvl[z]), 32'(mq[z].size()));
      chk("orun", z, 32'(o_run[z]), 32'(m_run[z]));
      chk("ovf_cnt", z, 32'(o_ovf[z]), 32'(m_ovf[z]));
      chk("udf_cnt", z, 32'(o_udf[z]), 32'(m_udf[z]));
    end
  endtask

  task automatic step(bit v, logic [W-1:0] i,
                      logic [W-1:0] q, bit a, bit b, bit f);
    val   = v;
    si    = i;
    sq    = q;
    ri    = a;
    rq    = b;
    flush = f;
    check_all();
    @(posedge clk_h);
    m_edge();
    @(negedge clk_h);
  endtask

  logic [31:0] wd [64];
  int nw;

  task automatic push(bit a, bit b);
    logic [31:0] r;
    r = $urandom;
    wd[nw] = r;
    nw++;
    step(1'b1, r[31:16], r[15:0], a, b, 1'b0);
  endtask

  task automatic zero_check(string nm);
    for (int z = 0; z < 2; z++) begin
      chk({nm, "_vi"}, z, 32'(o_vi[z]), 32'd0);
      chk({nm, "_vq"}, z, 32'(o_vq[z]), 32'd0);
      chk({nm, "_di"}, z, 32'(o_di[z]), 32'd0);
      chk({nm, "_lvl"}, z, 32'(o_lvl[z]), 32'd0);
      chk({nm, "_run"}, z, 32'(o_run[z]), 32'd0);
      chk({nm, "_ovf"}, z, 32'(o_ovf[z]), 32'd0);
      chk({nm, "_udf"}, z, 32'(o_udf[z]), 32'd0);
    end
  endtask

  typedef struct {
    bit           v;
    logic [W-1:0] i;
    logic [W-1:0] q;
    bit           ev;
    logic [W-1:0] ei;
    logic [W-1:0] eq;
    int           elvl;
  } vec_t;

  vec_t vec [32];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 32; k++) begin
      int b;
      b = k - 16;
      vec[k].v    = (k < 16);
      vec[k].i    = (k < 16) ? W'(k) : '0;
      vec[k].q    = (k < 16) ? W'(-k) : '0;
      vec[k].ev   = (k >= 16);
      vec[k].ei   = (k >= 16) ? W'(b) : '0;
      vec[k].eq   = (k >= 16) ? W'(-b) : '0;
      vec[k].elvl = (k < 16) ? k : 32 - k;
    end

    rst = 1'b1; flush = 1'b0; val = 1'b0;
    si = '0; sq = '0; ri = 1'b0; rq = 1'b0;
    nw = 0;
    m_clear();
    #12;
    zero_check("reset");
    @(negedge clk_h);
    rst = 1'b0;
    @(negedge clk_h);

    for (int k = 0; k < 32; k++) begin
      for (int z = 0; z < 2; z++) begin
        chk("vec_valid", z, 32'(o_vi[z]), 32'(vec[k].ev));
        chk("vec_di", z, 32'(o_di[z]), 32'(vec[k].ei));
        chk("vec_dq", z, 32'(o_dq[z]), 32'(vec[k].eq));
        chk("vec_lvl", z, 32'(o_lvl[z]), 32'(vec[k].elvl));
      end
      step(vec[k].v, vec[k].i, vec[k].q, 1'b1, 1'b1, 1'b0);
    end

    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    nw = 0;
    for (int j = 0; j < 20; j++)
      push(1'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      chk("bp_valid", 0, 32'(o_vi[0]), 32'd1);
      chk("bp_di", 0, 32'(o_di[0]), 32'(wd[0][31:16]));
      chk("bp_dq", 0, 32'(o_dq[0]), 32'(wd[0][15:0]));
      chk("bp_lvl", 0, 32'(o_lvl[0]), 32'd20);
      step(1'b0, '0, '0, c < 5, c >= 5, 1'b0);
    end

    for (int j = 0; j < 12; j++)
      push(1'b0, 1'b0);
    chk("ovf_before_full", 0, 32'(o_ovf[0]), 32'd0);
    for (int j = 0; j < 8; j++)
      push(1'b0, 1'b0);
    for (int z = 0; z < 2; z++) begin
      chk("ovf_level", z, 32'(o_lvl[z]), 32'd32);
      chk("ovf_count", z, 32'(o_ovf[z]), 32'd8);
    end

    for (int j = 0; j < 32; j++) begin
      chk("drain_di", 0, 32'(o_di[0]), 32'(wd[j][31:16]));
      step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    end
    for (int c = 0; c < 10; c++) begin
      chk("zf_valid", 0, 32'(o_vi[0]), 32'd1);
      chk("zf_di", 0, 32'(o_di[0]), 32'd0);
      chk("nz_valid", 1, 32'(o_vi[1]), 32'd0);
      step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    end
    chk("udf_count", 0, 32'(o_udf[0]), 32'd10);
    chk("udf_count", 1, 32'(o_udf[1]), 32'd0);
    chk("nz_run", 1, 32'(o_run[1]), 32'd0);

    step(1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
    chk("zhold_di", 0, 32'(o_di[0]), 32'd0);
    chk("zhold_valid", 0, 32'(o_vi[0]), 32'd1);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    chk("after_zero_di", 0, 32'(o_di[0]), 32'h1234);
    chk("after_zero_dq", 0, 32'(o_dq[0]), 32'h5678);
    chk("udf_count2", 0, 32'(o_udf[0]), 32'd11);

    for (int j = 0; j < 14; j++)
      push(1'b1, 1'b1);
    chk("nz_prefill_v", 1, 32'(o_vi[1]), 32'd0);
    push(1'b1, 1'b1);
    chk("nz_restart_v", 1, 32'(o_vi[1]), 32'd1);
    chk("nz_restart_di", 1, 32'(o_di[1]), 32'h1234);

    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 20; j++)
      push(1'b0, 1'b0);
    chk("pre_rst_lvl", 0, 32'(o_lvl[0]), 32'd20);
    #2 rst = 1'b1;
    #1 zero_check("async_rst");
    m_clear();
    @(negedge clk_h);
    rst = 1'b0;
    for (int j = 0; j < 16; j++)
      push(1'b1, 1'b1);
    chk("rst_restart_v", 0, 32'(o_vi[0]), 32'd1);

    for (int j = 0; j < 20; j++)
      push(1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    zero_check("flush");

    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      r = $urandom;
      step($urandom_range(0, 9) < 6, r[31:16], r[15:0],
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 499) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
